alu_share_arbiter: RTL
======================

# alu_share_arbiter

Two-requester round-robin arbiter and sequencer for the shared 5-bit mini-ALU (`_multiplexer`). Each requester presents an operation code and two operands through a valid/ready handshake. The arbiter grants one request at a time, drives the ALU's `sel`/`ina`/`inb` from registers, and captures the combinational `out` one cycle later. It returns the result with the winning requester's ID and holds it until the consumer accepts.

## Interface
- `WIDTH`, 5: operand/result width; must match the ALU.
- `SEL_W`, 3: operation-select width; must match the ALU.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req0_valid`, `req1_valid`  in  1  request pending.
- `req0_ready`, `req1_ready`  out  1  request accepted this cycle.
- `req0_sel`, `req1_sel`  in  SEL_W  operation code.
- `req0_ina`, `req1_ina`, `req0_inb`, `req1_inb`  in  WIDTH  operands.
- `alu_sel`  out  SEL_W  to ALU `sel`.
- `alu_ina`, `alu_inb`  out  WIDTH  to ALU `ina`/`inb`.
- `alu_out`  in  WIDTH  from ALU `out`; combinational function of `alu_*`.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  consumer accepts result.
- `res_data`  out  WIDTH  captured ALU result.
- `res_id`  out  1  requester that owns `res_data`.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE (2'd0), EXEC (2'd1), RESP (2'd2). Encoding 2'd3 is illegal and recovers to IDLE.
- **IDLE**
  - If exactly one `reqN_valid` is high, grant it.
  - If both are high, grant the requester selected by `rr_ptr` (0 means req0 wins).
  - Grant means: `reqN_ready`=1 in this cycle (combinational from state, valids and `rr_ptr` only). Latch `sel`/`ina`/`inb` into `alu_*`, latch the ID, go to EXEC.
  - With no valid request, stay in IDLE.
- **EXEC**: `alu_*` are stable. At the end of the cycle, capture `alu_out` into `res_data`, set `res_valid`, go to RESP.
- **RESP**
  - Hold `res_valid`, `res_data` and `res_id` stable until `res_ready`=1.
  - On acceptance: clear `res_valid`, set `rr_ptr` to the non-winner (`~res_id`), go to IDLE.
- `rr_ptr` changes only on result acceptance, so a requester that keeps `valid` asserted cannot be starved.
- `reqN_ready` is never high outside IDLE, and never high for both requesters at once.
- `alu_*` hold their last values outside grant cycles; they are not cleared after use.
- `sel` values 3'b101–3'b111 pass through unchanged. The ALU's response to them is whatever it produces; the arbiter does no decoding.
- Width rule: `res_data` is a straight WIDTH-bit copy of `alu_out`, with no extension or truncation.
- Requester rule: a requester must hold `valid` and its fields stable until `ready`. Dropping `valid` before `ready` withdraws the request with no side effects.

## Timing
- Accept in cycle T (`ready` high) → `alu_*` valid from T+1 → `res_valid` high from T+2.
- Minimum 3 cycles per operation when `res_ready` is held high. Peak throughput is 1 op / 3 cycles.
- Result-to-next-grant: the accept edge returns the FSM to IDLE, so the next grant is the following cycle at the earliest.
- Reset values while `rst_n`=0: state=IDLE, `rr_ptr`=0, and all of the following are 0:
  - `alu_sel`, `alu_ina`, `alu_inb`
  - `res_valid`, `res_data`, `res_id`, `busy`
  - `req0_ready`, `req1_ready`
- Reset asserted mid-operation (EXEC or RESP): the in-flight transaction is discarded with no result. After release, the first edge sees IDLE.
- `valid` arriving in the same cycle as `res_ready` acceptance in RESP is not granted that cycle. It is granted in the next (IDLE) cycle.

## Structure
- Shared package `alu_pkg`: `WIDTH`, `SEL_W`, the state typedef/localparams (IDLE/EXEC/RESP), and requester-ID constants `REQ0`=1'b0 and `REQ1`=1'b1.
- Sub-module `rr_pick2`, combinational:
  - inputs: the two valids and `rr_ptr`
  - outputs: `grant_any` and `grant_id`
- Top-level holds the FSM, operand registers and result register. The ALU is instantiated outside this block.

## Test plan
The bench ALU stub computes `alu_out = alu_ina + alu_inb` mod 32.
- **Single request**: req0 `sel`=3'b000, `ina`=5'b10110 (22), `inb`=5'b01011 (11), `res_ready`=1 → `req0_ready` in T, `alu_ina`=22 at T+1, `res_valid` at T+2 with `res_data`=5'd1 (33 mod 32) and `res_id`=0.
- **Simultaneous after reset**: both valid (req1 `ina`=3, `inb`=4) → req0 served first. Then req1 gets `res_data`=7, `res_id`=1. Then `rr_ptr`=0.
- **Fairness**: both valid continuously for 6 ops → grants alternate 0,1,0,1,0,1.
- **Backpressure**: `res_ready`=0 for 5 cycles in RESP → `res_data`/`res_id` stable, `busy`=1, both `ready` low. Accept on cycle 6 → IDLE the next cycle.
- **Reset mid-op**: `rst_n` low during EXEC → all outputs 0 immediately (asynchronous). After release, `res_valid` stays 0 until a new grant.
- **Withdraw**: req1 `valid` pulsed for one cycle while the arbiter is in RESP → no grant and no `res_id`=1 result ever produced.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the mini-ALU sharing arbiter: datapath widths,
// sequencer state encoding and requester identifiers.
package alu_pkg;

    localparam int WIDTH = 5;
    localparam int SEL_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/alu_share_arbiter_rr_pick2.sv
// Two-way round-robin pick: chooses which pending requester wins, using the
// priority pointer only when both are pending.
module rr_pick2
    import alu_pkg::*;
(
    input  logic valid0_i,
    input  logic valid1_i,
    input  logic rr_ptr_i,
    output logic grant_any_o,
    output logic grant_id_o
);

    // Winner selection; the pointer breaks ties only
    always_comb begin
        grant_any_o = valid0_i | valid1_i;
        if (valid0_i && valid1_i) begin
            grant_id_o = rr_ptr_i;
        end else if (valid1_i) begin
            grant_id_o = REQ1;
        end else begin
            grant_id_o = REQ0;
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter and sequencer sharing one combinational mini-ALU between
// two requesters; the result is held with its owner ID until accepted.
module alu_share_arbiter #(
    parameter int WIDTH = alu_pkg::WIDTH,
    parameter int SEL_W = alu_pkg::SEL_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic             req1_valid,
    output logic             req0_ready,
    output logic             req1_ready,
    input  logic [SEL_W-1:0] req0_sel,
    input  logic [SEL_W-1:0] req1_sel,
    input  logic [WIDTH-1:0] req0_ina,
    input  logic [WIDTH-1:0] req1_ina,
    input  logic [WIDTH-1:0] req0_inb,
    input  logic [WIDTH-1:0] req1_inb,
    output logic [SEL_W-1:0] alu_sel,
    output logic [WIDTH-1:0] alu_ina,
    output logic [WIDTH-1:0] alu_inb,
    input  logic [WIDTH-1:0] alu_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_id,
    output logic             busy
);

    import alu_pkg::*;

    state_e             state_q, state_d;
    logic               rr_ptr_q, rr_ptr_d;
    logic               gnt_id_q, gnt_id_d;
    logic [SEL_W-1:0]   alu_sel_q, alu_sel_d;
    logic [WIDTH-1:0]   alu_ina_q, alu_ina_d;
    logic [WIDTH-1:0]   alu_inb_q, alu_inb_d;
    logic               res_valid_q, res_valid_d;
    logic [WIDTH-1:0]   res_data_q, res_data_d;
    logic               res_id_q, res_id_d;
    logic               grant_any_s;
    logic               grant_id_s;

    rr_pick2 u_pick (
        .valid0_i    (req0_valid),
        .valid1_i    (req1_valid),
        .rr_ptr_i    (rr_ptr_q),
        .grant_any_o (grant_any_s),
        .grant_id_o  (grant_id_s)
    );

    // Next-state, grant handshake and register updates
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        gnt_id_d    = gnt_id_q;
        alu_sel_d   = alu_sel_q;
        alu_ina_d   = alu_ina_q;
        alu_inb_d   = alu_inb_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_id_d    = res_id_q;
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_any_s) begin
                    // Ready is masked by reset so no handshake completes while held
                    req0_ready = rst_n & (grant_id_s == REQ0);
                    req1_ready = rst_n & (grant_id_s == REQ1);
                    alu_sel_d  = (grant_id_s == REQ1) ? req1_sel : req0_sel;
                    alu_ina_d  = (grant_id_s == REQ1) ? req1_ina : req0_ina;
                    alu_inb_d  = (grant_id_s == REQ1) ? req1_inb : req0_inb;
                    gnt_id_d   = grant_id_s;
                    state_d    = EXEC;
                end else begin
                    state_d = IDLE;
                end
            end
            EXEC: begin
                res_data_d  = alu_out;
                res_id_d    = gnt_id_q;
                res_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    rr_ptr_d    = ~res_id_q;
                    state_d     = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, operand and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= 1'b0;
            gnt_id_q    <= 1'b0;
            alu_sel_q   <= {SEL_W{1'b0}};
            alu_ina_q   <= {WIDTH{1'b0}};
            alu_inb_q   <= {WIDTH{1'b0}};
            res_valid_q <= 1'b0;
            res_data_q  <= {WIDTH{1'b0}};
            res_id_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            gnt_id_q    <= gnt_id_d;
            alu_sel_q   <= alu_sel_d;
            alu_ina_q   <= alu_ina_d;
            alu_inb_q   <= alu_inb_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_id_q    <= res_id_d;
        end
    end

    assign alu_sel   = alu_sel_q;
    assign alu_ina   = alu_ina_q;
    assign alu_inb   = alu_inb_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_id    = res_id_q;
    assign busy      = (state_q != IDLE);

endmodule
